// File: rtl/noc_config_responder_pkg.sv
// Shared NoC flit constants, configuration struct and register map indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_config_responder_pkg;

  // Flit type field values, carried in flit bits [33:32]
  localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_LAST    = 2'b10;
  localparam logic [1:0] FLIT_SINGLE  = 2'b11;

  // Flit layout: type above a 32-bit data word
  localparam int FLIT_TYPE_MSB = 33;
  localparam int FLIT_TYPE_LSB = 32;

  // Header fields inside the data word
  localparam int HDR_DEST_MSB  = 31;
  localparam int HDR_DEST_LSB  = 27;
  localparam int HDR_CLASS_MSB = 26;
  localparam int HDR_CLASS_LSB = 24;
  localparam int HDR_SRC_MSB   = 23;
  localparam int HDR_SRC_LSB   = 19;

  // Register map indices (payload bits [7:0])
  localparam logic [7:0] REG_NUMCTS          = 8'd0;
  localparam logic [7:0] REG_CORES_PER_TILE  = 8'd1;
  localparam logic [7:0] REG_GMEM_SIZE       = 8'd2;
  localparam logic [7:0] REG_GMEM_TILE       = 8'd3;
  localparam logic [7:0] REG_LMEM_SIZE       = 8'd4;
  localparam logic [7:0] REG_TOTAL_NUM_CORES = 8'd5;
  localparam logic [7:0] REG_NOC_VCHANNELS   = 8'd6;
  localparam logic [7:0] REG_DEBUG_FLAGS     = 8'd7;
  localparam logic [7:0] REG_DEBUG_NUM_MODS  = 8'd8;
  localparam logic [7:0] REG_TILEID          = 8'd9;
  localparam logic [3:0] REG_CTLIST_HI_NIB   = 4'h1;  // indices 16..31

  localparam logic [31:0] REG_INVALID = 32'hFFFF_FFFF;

  // Derived system configuration; derivation happens upstream, this block only reads it
  typedef struct packed {
    logic [31:0]       NUMCTS;
    logic [31:0]       CORES_PER_TILE;
    logic [31:0]       GMEM_SIZE;
    logic [31:0]       GMEM_TILE;
    logic [31:0]       LMEM_SIZE;
    logic [31:0]       TOTAL_NUM_CORES;
    logic [31:0]       NOC_VCHANNELS;
    logic              USE_DEBUG;
    logic              DEBUG_STM;
    logic              DEBUG_CTM;
    logic [31:0]       DEBUG_NUM_MODS;
    logic [15:0][31:0] CTLIST;
    logic [31:0]       NOC_DATA_WIDTH;
    logic [31:0]       NOC_TYPE_WIDTH;
    logic [31:0]       NOC_FLIT_WIDTH;
  } config_t;

  localparam config_t DEFAULT_CONFIG = '{
    NOC_DATA_WIDTH: 32'd32,
    NOC_TYPE_WIDTH: 32'd2,
    NOC_FLIT_WIDTH: 32'd34,
    default:        '0
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV_IDX,
    ST_DRAIN,
    ST_SEND_HDR,
    ST_SEND_DATA
  } state_e;

endpackage

// File: rtl/noc_config_responder_config_reg_mux.sv
// Maps a configuration register index to its 32-bit value.
// Latency: purely combinational.
// Backpressure: none; no flow control.
module config_reg_mux
  import noc_config_responder_pkg::*;
#(
  parameter config_t     CONFIG = DEFAULT_CONFIG,
  parameter int unsigned TILEID = 0
) (
  input  logic [7:0]  idx,
  output logic [31:0] value
);

  localparam logic [4:0] TILE_ADDR = TILEID[4:0];

  // Index decode; unmapped indices read as all ones
  always_comb begin
    value = REG_INVALID;
    case (idx)
      REG_NUMCTS:          value = CONFIG.NUMCTS;
      REG_CORES_PER_TILE:  value = CONFIG.CORES_PER_TILE;
      REG_GMEM_SIZE:       value = CONFIG.GMEM_SIZE;
      REG_GMEM_TILE:       value = CONFIG.GMEM_TILE;
      REG_LMEM_SIZE:       value = CONFIG.LMEM_SIZE;
      REG_TOTAL_NUM_CORES: value = CONFIG.TOTAL_NUM_CORES;
      REG_NOC_VCHANNELS:   value = CONFIG.NOC_VCHANNELS;
      REG_DEBUG_FLAGS:     value = {29'b0, CONFIG.USE_DEBUG, CONFIG.DEBUG_STM, CONFIG.DEBUG_CTM};
      REG_DEBUG_NUM_MODS:  value = CONFIG.DEBUG_NUM_MODS;
      REG_TILEID:          value = {27'b0, TILE_ADDR};
      default: begin
        if (idx[7:4] == REG_CTLIST_HI_NIB) begin
          value = CONFIG.CTLIST[idx[3:0]];
        end
      end
    endcase
  end

endmodule

// File: rtl/noc_config_responder.sv
// NoC slave answering config-readback requests with a two-flit response.
// Latency: header valid one cycle after the index packet's LAST is accepted, data the cycle after.
// Backpressure: out_ready low holds the response flit; no request accepted while a response is pending.
module noc_config_responder
  import noc_config_responder_pkg::*;
#(
  parameter config_t     CONFIG     = DEFAULT_CONFIG,
  parameter int unsigned TILEID     = 0,
  parameter int          FLIT_WIDTH = int'(CONFIG.NOC_FLIT_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [4:0] TILE_ADDR = TILEID[4:0];

  state_e      state_q, state_d;
  logic [4:0]  src_q, src_d;
  logic [2:0]  class_q, class_d;
  logic [31:0] value_q, value_d;
  logic [31:0] lookup_value;

  logic [1:0]  in_type;
  logic        in_xfer;

  // Bits of the request word this block never looks at
  logic        unused_in_bits;
  assign unused_in_bits = ^{in_flit[31:27], in_flit[18:8]};

  assign in_type = in_flit[FLIT_TYPE_MSB:FLIT_TYPE_LSB];
  assign in_xfer = in_valid & in_ready;

  config_reg_mux #(
    .CONFIG (CONFIG),
    .TILEID (TILEID)
  ) u_config_reg_mux (
    .idx   (in_flit[7:0]),
    .value (lookup_value)
  );

  // Next-state, latch updates and flit assembly
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    class_d   = class_q;
    value_d   = value_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_flit  = '0;
    case (state_q)
      ST_IDLE: begin
        // Only a HEADER opens a request; SINGLE and stray PAYLOAD/LAST are swallowed
        in_ready = 1'b1;
        if (in_xfer && in_type == FLIT_HEADER) begin
          src_d   = in_flit[HDR_SRC_MSB:HDR_SRC_LSB];
          class_d = in_flit[HDR_CLASS_MSB:HDR_CLASS_LSB];
          state_d = ST_RECV_IDX;
        end
      end
      ST_RECV_IDX: begin
        // First flit after the header carries the index; HEADER/SINGLE here are ignored
        in_ready = 1'b1;
        if (in_xfer && in_type == FLIT_LAST) begin
          value_d = lookup_value;
          state_d = ST_SEND_HDR;
        end else if (in_xfer && in_type == FLIT_PAYLOAD) begin
          value_d = lookup_value;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        in_ready = 1'b1;
        if (in_xfer && in_type == FLIT_LAST) begin
          state_d = ST_SEND_HDR;
        end
      end
      ST_SEND_HDR: begin
        out_valid = 1'b1;
        out_flit  = {FLIT_HEADER, src_q, class_q, TILE_ADDR, 19'b0};
        if (out_ready) begin
          state_d = ST_SEND_DATA;
        end
      end
      ST_SEND_DATA: begin
        out_valid = 1'b1;
        out_flit  = {FLIT_LAST, value_q};
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset wins over everything, including a half-sent response
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_flit  = '0;
    end
  end

  // State and latch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      class_q <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      class_q <= class_d;
      value_q <= value_d;
    end
  end

endmodule

// File: tb/tb_noc_config_responder.sv
// Randomized scoreboard bench for noc_config_responder.
// Latency: n/a (testbench).
// Backpressure: drives out_ready low/random to exercise response holding.
module tb_noc_config_responder;
  import noc_config_responder_pkg::*;

  // System description the bench reasons about
  localparam int unsigned NUMCTS_V          = 4;
  localparam int unsigned CORES_PER_TILE_V  = 1;
  localparam int unsigned GMEM_SIZE_V       = 32'h0100_0000;
  localparam int unsigned GMEM_TILE_V       = 3;
  localparam int unsigned LMEM_SIZE_V       = 32'h0000_8000;
  localparam int unsigned TOTAL_CORES_V     = NUMCTS_V * CORES_PER_TILE_V;
  localparam int unsigned VCHANNELS_V       = 3;
  localparam int unsigned DEBUG_NUM_MODS_V  = 25;
  localparam int unsigned TILEID_V          = 2;
  localparam logic [4:0]  TILE5             = 5'd2;

  function automatic logic [31:0] ct_entry(input int i);
    return 32'hC7_000000 + 32'(i) * 32'h0001_0101;
  endfunction

  function automatic config_t make_cfg();
    config_t c;
    c = '0;
    c.NUMCTS          = NUMCTS_V;
    c.CORES_PER_TILE  = CORES_PER_TILE_V;
    c.GMEM_SIZE       = GMEM_SIZE_V;
    c.GMEM_TILE       = GMEM_TILE_V;
    c.LMEM_SIZE       = LMEM_SIZE_V;
    c.TOTAL_NUM_CORES = TOTAL_CORES_V;
    c.NOC_VCHANNELS   = VCHANNELS_V;
    c.USE_DEBUG       = 1'b1;
    c.DEBUG_STM       = 1'b1;
    c.DEBUG_CTM       = 1'b1;
    c.DEBUG_NUM_MODS  = DEBUG_NUM_MODS_V;
    for (int i = 0; i < 16; i++) c.CTLIST[i] = ct_entry(i);
    c.NOC_DATA_WIDTH  = 32;
    c.NOC_TYPE_WIDTH  = 2;
    c.NOC_FLIT_WIDTH  = 34;
    return c;
  endfunction

  localparam config_t TB_CFG = make_cfg();

  logic        clk = 1'b0;
  logic        rst;
  logic [33:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] out_flit;
  logic        out_valid;
  logic        out_ready;

  noc_config_responder #(.CONFIG(TB_CFG), .TILEID(TILEID_V)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] exp_q[$];
  logic [31:0] regmap [256];
  bit rand_rdy = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [33:0] exp_hdr(input logic [4:0] src, input logic [2:0] cls);
    return {2'b01, src, cls, TILE5, 19'b0};
  endfunction

  // Scoreboard monitor: every completed response flit must match the head of the queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got %h expected none", out_flit);
      end else begin
        check("resp_flit", 64'(out_flit), 64'(exp_q.pop_front()));
      end
    end
  end

  // Random downstream stall generator
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_flit(input logic [33:0] f);
    bit done = 0;
    in_flit  = f;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    in_flit  = '0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_accept_timeout: flit %h never accepted", f);
    end
  endtask

  // nfl = flits after the header (1: LAST carries index; >1: first PAYLOAD carries index)
  task automatic send_req(input logic [4:0] src, input logic [2:0] cls,
                          input logic [31:0] idx_word, input int nfl);
    exp_q.push_back(exp_hdr(src, cls));
    exp_q.push_back({2'b10, regmap[idx_word[7:0]]});
    send_flit({2'b01, TILE5, cls, src, 19'b0});
    if (nfl <= 1) begin
      send_flit({2'b10, idx_word});
    end else begin
      send_flit({2'b00, idx_word});
      for (int i = 0; i < nfl - 2; i++) send_flit({2'b00, 32'($urandom)});
      send_flit({2'b10, 32'($urandom)});
    end
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d flits still expected", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_out_valid(input string name);
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (out_valid) done = 1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: out_valid never rose", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) regmap[i] = 32'hFFFF_FFFF;
    regmap[0] = NUMCTS_V;
    regmap[1] = CORES_PER_TILE_V;
    regmap[2] = GMEM_SIZE_V;
    regmap[3] = GMEM_TILE_V;
    regmap[4] = LMEM_SIZE_V;
    regmap[5] = TOTAL_CORES_V;
    regmap[6] = VCHANNELS_V;
    regmap[7] = 32'd7;
    regmap[8] = DEBUG_NUM_MODS_V;
    regmap[9] = TILEID_V;
    for (int i = 0; i < 16; i++) regmap[16 + i] = ct_entry(i);

    rst = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_flit",  64'(out_flit),  64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Basic request with exact latency: LAST accepted at edge N
    send_req(5'd1, 3'd3, 32'd0, 1);
    @(negedge clk);
    check("lat_hdr_valid", 64'(out_valid), 64'd1);
    check("lat_hdr_flit",  64'(out_flit),  64'(exp_hdr(5'd1, 3'd3)));
    @(negedge clk);
    check("lat_data_valid", 64'(out_valid), 64'd1);
    check("lat_data_flit",  64'(out_flit),  64'({2'b10, 32'd4}));
    @(negedge clk);
    check("lat_idle_valid", 64'(out_valid), 64'd0);
    check("lat_idle_ready", 64'(in_ready),  64'd1);

    // Debug and out-of-map indices, plus ignored upper payload bits
    send_req(5'd7,  3'd0, 32'd8,   1); wait_drain("idx8");
    send_req(5'd30, 3'd5, 32'd7,   1); wait_drain("idx7");
    send_req(5'd4,  3'd1, 32'd200, 1); wait_drain("idx200");
    send_req(5'd9,  3'd2, 32'hABCD_EF09, 1); wait_drain("idx9_hi");

    // Four-flit request: index in first PAYLOAD, remaining flits drained
    send_req(5'd3, 3'd6, 32'd5, 3); wait_drain("multi");
    repeat (5) @(negedge clk);

    // SINGLE, stray LAST and stray PAYLOAD in IDLE are swallowed without a response
    send_flit({2'b11, 32'hDEAD_BEEF});
    send_flit({2'b10, 32'd0});
    send_flit({2'b00, 32'd1});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stray_no_resp", 64'(out_valid), 64'd0);
    end

    // Back-pressure during SEND_HDR
    out_ready = 1'b0;
    send_req(5'd12, 3'd4, 32'd17, 1);
    wait_out_valid("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hdr_hold",  64'(out_flit), 64'(exp_hdr(5'd12, 3'd4)));
      check("bp_in_ready",  64'(in_ready), 64'd0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    wait_drain("bp");
    repeat (5) @(negedge clk);

    // Reset while holding in SEND_DATA
    out_ready = 1'b0;
    send_req(5'd20, 3'd7, 32'd1, 1);
    wait_out_valid("rstmid");
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rstmid_pending", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rstmid_out_valid", 64'(out_valid), 64'd0);
    check("rstmid_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    send_req(5'd21, 3'd2, 32'd31, 2); wait_drain("rstmid_after");

    // Randomized traffic with random stalls
    rand_rdy = 1;
    for (int t = 0; t < 40; t++) begin
      logic [31:0] w;
      w = 32'($urandom);
      if ($urandom_range(0, 1) == 0) w[7:0] = 8'($urandom_range(0, 31));
      send_req(5'($urandom), 3'($urandom), w, $urandom_range(1, 4));
    end
    wait_drain("random");
    rand_rdy = 0;
    @(posedge clk); #2; out_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
